// File: rtl/axi_sram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axi_sram_slave                                                  |
// | Purpose  : AXI4 slave bridging single-beat/INCR bursts to one sync SRAM.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module axi_sram_slave #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 14
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // write address
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  // write data
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  // write response
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  // read address
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  // read data
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  // SRAM macro
  output logic                CEB,
  output logic                WEB,
  output logic [DATA_W-1:0]   BWEB,
  output logic [MEM_AW-1:0]   A,
  output logic [DATA_W-1:0]   DI,
  input  logic [DATA_W-1:0]   DO
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_R_FETCH = 3'd1,
    S_R_DATA  = 3'd2,
    S_W_DATA  = 3'd3,
    S_W_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;
  localparam logic [1:0] c_burst_fixed = 2'b00;

  state_t              r_state;
  logic                r_prio_rd;
  logic [ID_W-1:0]     r_id;
  logic [MEM_AW-1:0]   r_addr;
  logic [3:0]          r_len;
  logic [3:0]          r_cnt;
  logic                r_fixed;
  logic                r_err;
  logic                r_wready;
  logic                r_bvalid;
  logic [ID_W-1:0]     r_bid;
  logic [1:0]          r_bresp;
  logic                r_rvalid;
  logic                r_rlast;
  logic [ID_W-1:0]     r_rid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rfirst;

  logic                w_idle;
  logic                w_ar_go;
  logic                w_aw_go;
  logic                w_wbeat;
  logic                w_last;
  logic [MEM_AW-1:0]   w_next_addr;
  logic [DATA_W-1:0]   w_bweb;

  // Size and out-of-window address bits carry no meaning for this slave.
  logic w_unused;
  assign w_unused = ^{AWSIZE, ARSIZE,
                      AWADDR[ADDR_W-1:MEM_AW+2], AWADDR[1:0],
                      ARADDR[ADDR_W-1:MEM_AW+2], ARADDR[1:0]};

  assign w_idle      = (r_state == S_IDLE);
  assign w_ar_go     = w_idle & ARVALID & ~(AWVALID & ~r_prio_rd);
  assign w_aw_go     = w_idle & AWVALID & ~(ARVALID & r_prio_rd);
  assign w_wbeat     = (r_state == S_W_DATA) & WVALID;
  assign w_last      = (r_cnt == r_len);
  assign w_next_addr = r_fixed ? r_addr : r_addr + {{(MEM_AW-1){1'b0}}, 1'b1};

  always_comb begin
    w_bweb = '1;
    for (int k = 0; k < DATA_W/8; k++) begin
      w_bweb[k*8 +: 8] = ~{8{WSTRB[k]}};
    end
  end

  assign ARREADY = w_ar_go;
  assign AWREADY = w_aw_go;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BID     = r_bid;
  assign BRESP   = r_bresp;
  assign RVALID  = r_rvalid;
  assign RLAST   = r_rlast;
  assign RID     = r_rid;
  assign RRESP   = c_resp_okay;
  // SRAM output is only valid in the first R_DATA cycle; hold a copy after that.
  assign RDATA   = r_rfirst ? DO : r_rdata;

  // Write beats hit the SRAM in the same cycle WVALID is seen.
  assign CEB  = ~((r_state == S_R_FETCH) | w_wbeat);
  assign WEB  = ~w_wbeat;
  assign A    = r_addr;
  assign DI   = w_wbeat ? WDATA : '0;
  assign BWEB = w_wbeat ? w_bweb : '1;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= S_IDLE;
      r_prio_rd <= 1'b0;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_fixed   <= 1'b0;
      r_err     <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= c_resp_okay;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rfirst  <= 1'b0;
    end else begin
      r_rfirst <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ar_go) begin
            r_id      <= ARID;
            r_addr    <= ARADDR[MEM_AW+1:2];
            r_len     <= ARLEN;
            r_fixed   <= (ARBURST == c_burst_fixed);
            r_cnt     <= '0;
            r_prio_rd <= 1'b0;
            r_state   <= S_R_FETCH;
          end else if (w_aw_go) begin
            r_id      <= AWID;
            r_addr    <= AWADDR[MEM_AW+1:2];
            r_len     <= AWLEN;
            r_fixed   <= (AWBURST == c_burst_fixed);
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_wready  <= 1'b1;
            r_prio_rd <= 1'b1;
            r_state   <= S_W_DATA;
          end
        end

        S_R_FETCH: begin
          r_rvalid <= 1'b1;
          r_rlast  <= w_last;
          r_rid    <= r_id;
          r_rfirst <= 1'b1;
          r_state  <= S_R_DATA;
        end

        S_R_DATA: begin
          if (r_rfirst) begin
            r_rdata <= DO;
          end
          if (RREADY) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= r_cnt + 4'd1;
              r_addr  <= w_next_addr;
              r_state <= S_R_FETCH;
            end
          end
        end

        S_W_DATA: begin
          if (WVALID) begin
            if (w_last) begin
              // A missing WLAST on the final beat is an error too.
              r_bresp  <= (r_err | ~WLAST) ? c_resp_slverr : c_resp_okay;
              r_bid    <= r_id;
              r_bvalid <= 1'b1;
              r_wready <= 1'b0;
              r_state  <= S_W_RESP;
            end else begin
              r_err  <= r_err | WLAST;
              r_cnt  <= r_cnt + 4'd1;
              r_addr <= w_next_addr;
            end
          end
        end

        S_W_RESP: begin
          if (BREADY) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axi_sram_slave                                               |
// | Purpose  : Directed scoreboard bench for axi_sram_slave with an SRAM model. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_axi_sram_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [7:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA, BWEB, DI, DO;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, CEB, WEB;
  logic [13:0] A;

  logic        pl_en;
  logic [13:0] pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem [0:16383];

  typedef struct packed { logic [7:0] id; logic [31:0] data; logic last; } rexp_t;
  typedef struct packed { logic [7:0] id; logic [1:0] resp; } bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];

  int errors = 0;
  int checks = 0;

  always #5 ACLK = ~ACLK;

  axi_sram_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(DO)
  );

  // Synchronous SRAM: one-cycle read latency, active-low bit mask on writes.
  always @(posedge ACLK) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (!CEB) begin
      if (!WEB) mem[A] <= (mem[A] & BWEB) | (DI & ~BWEB);
      else      DO <= mem[A];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [13:0] wa, input logic [31:0] d);
    @(posedge ACLK); #1;
    pl_en = 1'b1; pl_addr = wa; pl_data = d;
    @(posedge ACLK); #1;
    pl_en = 1'b0;
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    int n;
    @(posedge ACLK); #1;
    ARID = id; ARADDR = addr; ARLEN = len; ARBURST = 2'b01; ARSIZE = 3'b010; ARVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!ARREADY && n < 20) begin @(negedge ACLK); n++; end
    if (!ARREADY) chk("arready_timeout", ARREADY, 1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    int n;
    @(posedge ACLK); #1;
    AWID = id; AWADDR = addr; AWLEN = len; AWBURST = 2'b01; AWSIZE = 3'b010; AWVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!AWREADY && n < 20) begin @(negedge ACLK); n++; end
    if (!AWREADY) chk("awready_timeout", AWREADY, 1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
  endtask

  // Called just after a handshake edge; expects RVALID two cycles later.
  task automatic get_rbeat(input int stall);
    int lat;
    rexp_t e;
    lat = 0;
    do begin @(negedge ACLK); lat++; end while (!RVALID && lat < 20);
    if (!RVALID) begin
      chk("rvalid_timeout", RVALID, 1);
      return;
    end
    chk("r_latency", lat, 2);
    if (rq.size() == 0) begin
      chk("r_unexpected_beat", RVALID, 0);
    end else begin
      e = rq.pop_front();
      chk("rdata", RDATA, e.data);
      chk("rid", RID, e.id);
      chk("rlast", RLAST, e.last);
      chk("rresp", RRESP, 2'b00);
      if (stall > 0) begin
        RREADY = 1'b0;
        repeat (stall) begin
          @(negedge ACLK);
          chk("rvalid_stall", RVALID, 1);
          chk("rdata_stall", RDATA, e.data);
          chk("rlast_stall", RLAST, e.last);
        end
        RREADY = 1'b1;
      end
    end
    @(posedge ACLK); #1;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] strb, input logic last,
                        input logic [13:0] exp_a, input logic [31:0] exp_bweb);
    WDATA = d; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    @(negedge ACLK);
    chk("wready", WREADY, 1);
    chk("w_ceb", CEB, 0);
    chk("w_web", WEB, 0);
    chk("w_a", A, exp_a);
    chk("w_di", DI, d);
    chk("w_bweb", BWEB, exp_bweb);
    @(posedge ACLK); #1;
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic get_b();
    int n;
    bexp_t e;
    n = 0;
    @(negedge ACLK);
    while (!BVALID && n < 20) begin @(negedge ACLK); n++; end
    if (!BVALID) begin
      chk("bvalid_timeout", BVALID, 1);
      return;
    end
    chk("ceb_wresp", CEB, 1);
    if (bq.size() == 0) begin
      chk("b_unexpected", BVALID, 0);
    end else begin
      e = bq.pop_front();
      chk("bid", BID, e.id);
      chk("bresp", BRESP, e.resp);
    end
    @(posedge ACLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ARESETn = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'b010; ARBURST = 2'b01; ARVALID = 1'b0;
    RREADY = 1'b1;

    // Reset values
    #12;
    chk("rst_awready", AWREADY, 0); chk("rst_arready", ARREADY, 0);
    chk("rst_wready", WREADY, 0);   chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);   chk("rst_rlast", RLAST, 0);
    chk("rst_ids", {BID, RID}, 16'h0);
    chk("rst_resp", {BRESP, RRESP}, 4'h0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_sram", {CEB, WEB, BWEB, A, DI}, {1'b1, 1'b1, 32'hFFFF_FFFF, 14'h0, 32'h0});

    preload(14'h101, 32'h5555_AAAA);
    preload(14'h010, 32'hDEAD_BEEF);
    preload(14'h040, 32'd1); preload(14'h041, 32'd2);
    preload(14'h042, 32'd3); preload(14'h043, 32'd4);
    preload(14'h002, 32'h1122_3344);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;

    // Simultaneous AW/AR right after reset: W, R, W
    for (int i = 0; i < 3; i++) begin
      logic exp_w;
      exp_w = (i != 1);
      @(posedge ACLK); #1;
      AWID = 8'h10 + 8'(i); AWADDR = 32'h400; AWLEN = 4'd0; AWVALID = 1'b1;
      ARID = 8'h20 + 8'(i); ARADDR = 32'h404; ARLEN = 4'd0; ARVALID = 1'b1;
      @(negedge ACLK);
      chk("arb_awready", AWREADY, exp_w);
      chk("arb_arready", ARREADY, !exp_w);
      @(posedge ACLK); #1;
      AWVALID = 1'b0; ARVALID = 1'b0;
      if (exp_w) begin
        bq.push_back('{id: 8'h10 + 8'(i), resp: 2'b00});
        w_beat(32'hC0DE_0000 + 32'(i), 4'hF, 1'b1, 14'h100, 32'h0);
        get_b();
      end else begin
        rq.push_back('{id: 8'h20 + 8'(i), data: 32'h5555_AAAA, last: 1'b1});
        get_rbeat(0);
      end
    end

    // Single read
    send_ar(8'h01, 32'h40, 4'd0);
    rq.push_back('{id: 8'h01, data: 32'hDEAD_BEEF, last: 1'b1});
    get_rbeat(0);

    // 4-beat INCR read with a 3-cycle stall on beat 2
    send_ar(8'h02, 32'h100, 4'd3);
    for (int b = 0; b < 4; b++) rq.push_back('{id: 8'h02, data: 32'(b + 1), last: (b == 3)});
    get_rbeat(0); get_rbeat(3); get_rbeat(0); get_rbeat(0);

    // Partial write over 0x11223344, then read back
    send_aw(8'h05, 32'h8, 4'd0);
    bq.push_back('{id: 8'h05, resp: 2'b00});
    w_beat(32'hAABB_CCDD, 4'b0011, 1'b1, 14'h002, 32'hFFFF_0000);
    get_b();
    send_ar(8'h05, 32'h8, 4'd0);
    rq.push_back('{id: 8'h05, data: 32'h1122_CCDD, last: 1'b1});
    get_rbeat(0);

    // WLAST on the wrong beat: both words written, SLVERR
    send_aw(8'h06, 32'h20, 4'd1);
    bq.push_back('{id: 8'h06, resp: 2'b10});
    w_beat(32'hA5A5_0001, 4'hF, 1'b1, 14'h008, 32'h0);
    w_beat(32'hA5A5_0002, 4'hF, 1'b0, 14'h009, 32'h0);
    get_b();
    send_ar(8'h06, 32'h20, 4'd1);
    rq.push_back('{id: 8'h06, data: 32'hA5A5_0001, last: 1'b0});
    rq.push_back('{id: 8'h06, data: 32'hA5A5_0002, last: 1'b1});
    get_rbeat(0); get_rbeat(0);

    // Reset asserted during beat 2 of a 4-beat read
    send_ar(8'h03, 32'h100, 4'd3);
    for (int b = 0; b < 4; b++) rq.push_back('{id: 8'h03, data: 32'(b + 1), last: (b == 3)});
    get_rbeat(0);
    begin
      int n;
      n = 0;
      @(negedge ACLK);
      while (!RVALID && n < 20) begin @(negedge ACLK); n++; end
      chk("mid_rvalid_b2", RVALID, 1);
      chk("mid_rdata_b2", RDATA, 32'd2);
    end
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_rvalid", RVALID, 0);
    chk("mid_rst_rlast", RLAST, 0);
    chk("mid_rst_rdata", RDATA, 32'h0);
    chk("mid_rst_rid", RID, 8'h0);
    chk("mid_rst_sram", {CEB, WEB, BWEB, A, DI}, {1'b1, 1'b1, 32'hFFFF_FFFF, 14'h0, 32'h0});
    chk("mid_rst_ready", {ARREADY, AWREADY, WREADY, BVALID}, 4'h0);
    rq.delete();
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;

    send_ar(8'h04, 32'h40, 4'd0);
    rq.push_back('{id: 8'h04, data: 32'hDEAD_BEEF, last: 1'b1});
    get_rbeat(0);

    chk("rq_drained", rq.size(), 0);
    chk("bq_drained", bq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
